// File: rtl/uart_rx_frame.sv
// UART receiver: deserialises start/data/parity/stop frames onto a valid/ready word port.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_rx,
  output logic [DATA_WIDTH-1:0] data_rx,
  output logic                  valid_rx,
  input  logic                  ready_rx,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  input  logic [3:0]            br,
  input  logic [1:0]            sbl,
  input  logic                  parity_on,
  input  logic                  parity_set,
  input  logic                  seniority_h
);

  localparam int unsigned CNT_W = $clog2(CLK_FREQ / 1200 + 2);
  localparam int unsigned BCW   = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] BIT_1200   = CNT_W'(CLK_FREQ / 1200);
  localparam logic [CNT_W-1:0] BIT_2400   = CNT_W'(CLK_FREQ / 2400);
  localparam logic [CNT_W-1:0] BIT_4800   = CNT_W'(CLK_FREQ / 4800);
  localparam logic [CNT_W-1:0] BIT_9600   = CNT_W'(CLK_FREQ / 9600);
  localparam logic [CNT_W-1:0] BIT_19200  = CNT_W'(CLK_FREQ / 19200);
  localparam logic [CNT_W-1:0] BIT_38400  = CNT_W'(CLK_FREQ / 38400);
  localparam logic [CNT_W-1:0] BIT_57600  = CNT_W'(CLK_FREQ / 57600);
  localparam logic [CNT_W-1:0] BIT_115200 = CNT_W'(CLK_FREQ / 115200);
  localparam logic [CNT_W-1:0] BIT_230400 = CNT_W'(CLK_FREQ / 230400);
  localparam logic [CNT_W-1:0] BIT_460800 = CNT_W'(CLK_FREQ / 460800);
  localparam logic [CNT_W-1:0] BIT_921600 = CNT_W'(CLK_FREQ / 921600);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                r_state;
  logic [1:0]            r_sync;
  logic [CNT_W-1:0]      r_cnt;
  logic [BCW-1:0]        r_bits;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_stop_n;
  logic                  r_stop_bad;
  logic                  r_perr_nx;
  logic [3:0]            r_br;
  logic                  r_two_stop;
  logic                  r_par_on;
  logic                  r_par_set;
  logic                  r_msb;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_perr;
  logic                  r_ferr;
  logic                  r_ovr;

  logic                  w_rx;
  logic [CNT_W-1:0]      w_bit;
  logic [CNT_W-1:0]      w_target;
  logic                  w_fire;
  logic                  w_sample;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[0], signal_rx};
  end

  assign w_rx = r_sync[1];

  always_comb begin
    w_bit = BIT_115200;
    case (r_br)
      4'd0:    w_bit = BIT_1200;
      4'd1:    w_bit = BIT_2400;
      4'd2:    w_bit = BIT_4800;
      4'd3:    w_bit = BIT_9600;
      4'd4:    w_bit = BIT_19200;
      4'd5:    w_bit = BIT_38400;
      4'd6:    w_bit = BIT_57600;
      4'd8:    w_bit = BIT_230400;
      4'd9:    w_bit = BIT_460800;
      4'd10:   w_bit = BIT_921600;
      default: ;
    endcase
  end

  assign w_target = (r_state == START) ? (w_bit >> 1) : w_bit;

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one cycle past the centre; reloading to 2 keeps later centres on the bit grid.
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(2);
  logic r_s0;
  logic r_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      if (r_cnt == w_target - CNT_W'(1)) r_s0 <= w_rx;
      if (r_cnt == w_target)             r_s1 <= w_rx;
    end
  end

  assign w_fire   = (r_cnt == w_target + CNT_W'(1));
  assign w_sample = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
`else
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(1);
  assign w_fire   = (r_cnt == w_target);
  assign w_sample = w_rx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bits     <= '0;
      r_shift    <= '0;
      r_stop_n   <= 1'b0;
      r_stop_bad <= 1'b0;
      r_perr_nx  <= 1'b0;
      r_br       <= '0;
      r_two_stop <= 1'b0;
      r_par_on   <= 1'b0;
      r_par_set  <= 1'b0;
      r_msb      <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (r_valid && ready_rx) r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx) begin
            r_state    <= START;
            r_cnt      <= CNT_W'(1);
            r_br       <= br;
            r_two_stop <= sbl[1];
            r_par_on   <= parity_on;
            r_par_set  <= parity_set;
            r_msb      <= seniority_h;
          end
        end
        START: begin
          if (w_fire) begin
            r_cnt  <= CNT_RELOAD;
            r_bits <= '0;
            r_state <= w_sample ? IDLE : DATA;
          end
        end
        DATA: begin
          if (w_fire) begin
            r_cnt  <= CNT_RELOAD;
            r_bits <= r_bits + BCW'(1);
            if (r_msb) r_shift <= DATA_WIDTH'({r_shift, w_sample});
            else       r_shift <= DATA_WIDTH'({w_sample, r_shift} >> 1);
            if (r_bits == BCW'(DATA_WIDTH - 1)) begin
              r_state    <= r_par_on ? PARITY : STOP;
              r_stop_n   <= 1'b0;
              r_stop_bad <= 1'b0;
              r_perr_nx  <= 1'b0;
            end
          end
        end
        PARITY: begin
          if (w_fire) begin
            r_cnt     <= CNT_RELOAD;
            r_perr_nx <= (^r_shift) ^ w_sample ^ r_par_set;
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_fire) begin
            r_cnt <= CNT_RELOAD;
            if (r_two_stop && !r_stop_n) begin
              r_stop_n   <= 1'b1;
              r_stop_bad <= !w_sample;
            end else begin
              r_state <= IDLE;
              if (r_stop_bad || !w_sample) begin
                r_ferr <= 1'b1;
              end else if (!r_valid || ready_rx) begin
                r_data  <= r_shift;
                r_perr  <= r_perr_nx;
                r_valid <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_rx     = r_data;
  assign valid_rx    = r_valid;
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
  assign overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed and randomized bench for uart_rx_frame with a frame-level reference model.
module tb_uart_rx_frame;
  localparam int unsigned CLK_HZ = 100_000_000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       signal_rx = 1'b1;
  logic [7:0] data_rx;
  logic       valid_rx;
  logic       ready_rx = 1'b0;
  logic       parity_err, frame_err, overrun_err;
  logic [3:0] br = 4'd7;
  logic [1:0] sbl = 2'd0;
  logic       parity_on = 1'b0, parity_set = 1'b0, seniority_h = 1'b0;

  int checks = 0, errors = 0, cyc = 0;
  int c_br = 7, c_sbl = 0;
  bit c_pon = 0, c_pset = 0, c_msb = 0;

  int n_rise = 0, rise_cyc = 0, n_ferr = 0, ferr_cyc = 0, n_ferr_long = 0;
  int n_ovr = 0, ovr_cyc = 0, n_ovr_long = 0, n_unstable = 0;
  logic [7:0] rise_data = '0, p_data = '0;
  logic rise_perr = 1'b0, p_valid = 1'b0, p_ferr = 1'b0, p_ovr = 1'b0, p_ready = 1'b0;
  int b_rise, b_ferr, b_ferr_long, b_ovr, b_ovr_long;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame #(.DATA_WIDTH(8), .CLK_FREQ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .signal_rx(signal_rx),
    .data_rx(data_rx), .valid_rx(valid_rx), .ready_rx(ready_rx),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
    .br(br), .sbl(sbl), .parity_on(parity_on), .parity_set(parity_set),
    .seniority_h(seniority_h)
  );

  always @(negedge clk) begin
    if (valid_rx && !p_valid) begin
      n_rise++; rise_cyc = cyc; rise_data = data_rx; rise_perr = parity_err;
    end
    if (frame_err) begin n_ferr++; ferr_cyc = cyc; end
    if (frame_err && p_ferr) n_ferr_long++;
    if (overrun_err) begin n_ovr++; ovr_cyc = cyc; end
    if (overrun_err && p_ovr) n_ovr_long++;
    if (p_valid && valid_rx && !p_ready && !ready_rx && data_rx !== p_data) n_unstable++;
    p_valid = valid_rx; p_ferr = frame_err; p_ovr = overrun_err;
    p_ready = ready_rx; p_data = data_rx;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int bit_len(int sel);
    case (sel)
      0: return CLK_HZ / 1200;     1: return CLK_HZ / 2400;
      2: return CLK_HZ / 4800;     3: return CLK_HZ / 9600;
      4: return CLK_HZ / 19200;    5: return CLK_HZ / 38400;
      6: return CLK_HZ / 57600;    8: return CLK_HZ / 230400;
      9: return CLK_HZ / 460800;   10: return CLK_HZ / 921600;
      default: return CLK_HZ / 115200;
    endcase
  endfunction

  // Word value from line-order bits: the k-th bit on the wire has weight 2^k or 2^(7-k).
  function automatic logic [7:0] model_word(logic [7:0] lb, bit msb);
    int w = 0;
    for (int i = 0; i < 8; i++)
      if (lb[i]) w += 1 << (msb ? 7 - i : i);
    return 8'(w);
  endfunction

  function automatic int frame_latency(int sel, bit pon, int sb);
    int b = bit_len(sel);
    return 3 + b / 2 + (8 + int'(pon) + ((sb >= 2) ? 2 : 1)) * b;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(string tag, int obs, int exp);
    checks++;
    assert (obs >= exp - 2 && obs <= exp + 2) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d(+-2)", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_rise = n_rise; b_ferr = n_ferr; b_ferr_long = n_ferr_long;
    b_ovr = n_ovr; b_ovr_long = n_ovr_long;
  endtask

  task automatic apply_cfg();
    br = 4'(c_br); sbl = 2'(c_sbl); parity_on = c_pon;
    parity_set = c_pset; seniority_h = c_msb;
  endtask

  // Entered and left on a negedge; t0 is the cycle index at which the line falls.
  task automatic send_frame(input logic [7:0] lb, input bit flip, input logic stop_lvl,
                            input bit scramble, output int t0);
    int b, h;
    logic pbit;
    apply_cfg();
    b = bit_len(c_br);
    h = b / 2;
    t0 = cyc;
    signal_rx = 1'b0;
    repeat (h) @(negedge clk);
    if (scramble) begin
      br = 4'($urandom); sbl = 2'($urandom); parity_on = 1'($urandom);
      parity_set = 1'($urandom); seniority_h = 1'($urandom);
    end
    repeat (b - h) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      signal_rx = lb[i];
      repeat (b) @(negedge clk);
    end
    if (c_pon) begin
      pbit = ((($countones(lb) % 2) == 1) != c_pset) != flip;
      signal_rx = pbit;
      repeat (b) @(negedge clk);
    end
    signal_rx = stop_lvl;
    repeat (b) @(negedge clk);
    signal_rx = 1'b1;
    if (c_sbl == 1) repeat (h) @(negedge clk);
    else if (c_sbl >= 2) repeat (b) @(negedge clk);
    apply_cfg();
  endtask

  task automatic expect_word(string tag, logic [7:0] lb, bit flip, int t0);
    check({tag, "_rise"}, n_rise - b_rise, 1);
    check({tag, "_data"}, rise_data, model_word(lb, c_msb));
    check({tag, "_held"}, data_rx, model_word(lb, c_msb));
    check({tag, "_valid"}, valid_rx, 1'b1);
    check({tag, "_perr"}, rise_perr, c_pon & flip);
    check({tag, "_noflag"}, (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);
    check_near({tag, "_latency"}, rise_cyc - t0, frame_latency(c_br, c_pon, c_sbl));
  endtask

  task automatic consume(string tag);
    ready_rx = 1'b1;
    @(negedge clk);
    ready_rx = 1'b0;
    check(tag, valid_rx, 1'b0);
  endtask

  initial begin
    int t0, t1, b;
    logic [7:0] lb;
    bit fl;
    repeat (3) @(negedge clk);
    check("rst_data", data_rx, 8'h00);
    check("rst_valid", valid_rx, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun_err, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 115200 baud, 8N1, LSB first, held until accepted
    c_br = 7; c_sbl = 0; c_pon = 0; c_pset = 0; c_msb = 0;
    snap(); send_frame(8'hA5, 0, 1'b1, 0, t0);
    expect_word("a5", 8'hA5, 0, t0);
    repeat (50) @(negedge clk);
    check("a5_hold_valid", valid_rx, 1'b1);
    check("a5_hold_data", data_rx, 8'hA5);
    consume("a5_ack");

    // Even parity: wrong parity bit then correct parity bit
    c_br = 10; c_pon = 1; c_pset = 0;
    snap(); send_frame(8'h3C, 1, 1'b1, 0, t0);
    expect_word("par_bad", 8'h3C, 1, t0);
    check("par_bad_flag", parity_err, 1'b1);
    consume("par_bad_ack");
    snap(); send_frame(8'h3C, 0, 1'b1, 0, t0);
    expect_word("par_ok", 8'h3C, 0, t0);
    check("par_ok_flag", parity_err, 1'b0);
    consume("par_ok_ack");

    // Wire order 1,1,0,0,0,0,0,1 under both bit orders
    c_pon = 0; c_msb = 1;
    snap(); send_frame(8'h83, 0, 1'b1, 0, t0);
    expect_word("msb", 8'h83, 0, t0);
    check("msb_c1", data_rx, 8'hC1);
    consume("msb_ack");
    c_msb = 0;
    snap(); send_frame(8'h83, 0, 1'b1, 0, t0);
    expect_word("lsb", 8'h83, 0, t0);
    check("lsb_83", data_rx, 8'h83);
    consume("lsb_ack");

    // Low stop bit
    snap(); send_frame(8'h77, 0, 1'b0, 0, t0);
    repeat (3 * bit_len(c_br)) @(negedge clk);
    check("ferr_count", n_ferr - b_ferr, 1);
    check("ferr_width", n_ferr_long - b_ferr_long, 0);
    check("ferr_norise", n_rise - b_rise, 0);
    check("ferr_valid", valid_rx, 1'b0);
    check_near("ferr_latency", ferr_cyc - t0, frame_latency(c_br, c_pon, c_sbl));
    snap(); send_frame(8'h5A, 0, 1'b1, 0, t0);
    expect_word("after_ferr", 8'h5A, 0, t0);

    // Short low glitch on the idle line at 115200
    c_br = 7; apply_cfg(); snap();
    signal_rx = 1'b0;
    repeat (200) @(negedge clk);
    signal_rx = 1'b1;
    repeat (1500) @(negedge clk);
    check("glitch_norise", n_rise - b_rise, 0);
    check("glitch_noflags", (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);
    check("glitch_keep", data_rx, 8'h5A);

    // Reset in the middle of a frame while a word is presented
    c_br = 10; apply_cfg();
    signal_rx = 1'b0;
    repeat (3 * bit_len(c_br)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_data", data_rx, 8'h00);
    check("mrst_valid", valid_rx, 1'b0);
    check("mrst_perr", parity_err, 1'b0);
    check("mrst_ferr", frame_err, 1'b0);
    check("mrst_ovr", overrun_err, 1'b0);
    signal_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    snap(); send_frame(8'h11, 0, 1'b1, 0, t0);
    expect_word("post_rst", 8'h11, 0, t0);
    consume("post_rst_ack");

    // Back-to-back frames with the consumer stalled
    snap();
    send_frame(8'h11, 0, 1'b1, 0, t0);
    send_frame(8'h22, 0, 1'b1, 0, t1);
    repeat (20) @(negedge clk);
    check("ovr_rise", n_rise - b_rise, 1);
    check("ovr_data", data_rx, 8'h11);
    check("ovr_valid", valid_rx, 1'b1);
    check("ovr_count", n_ovr - b_ovr, 1);
    check("ovr_width", n_ovr_long - b_ovr_long, 0);
    check_near("ovr_latency", ovr_cyc - t1, frame_latency(c_br, c_pon, c_sbl));
    consume("ovr_ack");

    // Random words and formats, config inputs disturbed mid-frame
    for (int n = 0; n < 10; n++) begin
      c_br = 9 + int'($urandom_range(0, 1));
      c_sbl = int'($urandom_range(0, 3));
      c_pon = 1'($urandom); c_pset = 1'($urandom); c_msb = 1'($urandom);
      lb = 8'($urandom);
      fl = 1'($urandom);
      snap(); send_frame(lb, fl, 1'b1, 1, t0);
      expect_word($sformatf("rnd%0d", n), lb, fl, t0);
      consume($sformatf("rnd%0d_ack", n));
      b = int'($urandom_range(0, 30));
      repeat (b) @(negedge clk);
    end

    check("data_stable", n_unstable, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
